// File: rtl/dvp_delta_capture_pkg.sv
// Shared definitions for the DVP frame-delta capture block: FSM encoding and byte-lane geometry.
package dvp_delta_capture_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } cap_state_e;

    localparam int DEF_DATA_WIDTH = 256;
    localparam int BYTE_LANE_W    = 8;

    function automatic int lane_count(input int data_width);
        return data_width / BYTE_LANE_W;
    endfunction

endpackage

// File: rtl/dvp_delta_capture_if.sv
// Camera-side DVP inputs plus the frame-delta valid/ready output channel.
interface dvp_delta_capture_if #(
    parameter int DATA_WIDTH = 256,
    parameter int BYTE_CNT_W = 24
);
    logic                  cam_pclk;
    logic                  cam_vsync;
    logic                  cam_href;
    logic [7:0]            cam_data;
    logic [DATA_WIDTH-1:0] frame_delta;
    logic                  delta_valid;
    logic                  delta_ready;
    logic [BYTE_CNT_W-1:0] frame_bytes;
    logic [15:0]           frames_dropped;

    modport master (
        input  cam_pclk, cam_vsync, cam_href, cam_data, delta_ready,
        output frame_delta, delta_valid, frame_bytes, frames_dropped
    );

    modport slave (
        output cam_pclk, cam_vsync, cam_href, cam_data, delta_ready,
        input  frame_delta, delta_valid, frame_bytes, frames_dropped
    );
endinterface

// File: rtl/dvp_sync.sv
// Two-flop synchronizer with a one-cycle rising-edge strobe on the synchronized value.
module dvp_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] meta_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] prev_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= '0;
            sync_p1 <= '0;
            prev_p2 <= '0;
        end else begin
            meta_p0 <= async_in;
            sync_p1 <= meta_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign sync_out = sync_p1;
    assign rise     = sync_p1 & ~prev_p2;
endmodule

// File: rtl/dvp_delta_capture.sv
// Captures DVP frames into an XOR-folded byte-lane hash and hands each nonempty frame
// downstream over a valid/ready channel, counting frames lost to backpressure.
module dvp_delta_capture
    import dvp_delta_capture_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BYTE_CNT_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                capture_en,
    dvp_delta_capture_if.master bus
);
    localparam int LANES = lane_count(DATA_WIDTH);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    function automatic logic [BYTE_CNT_W-1:0] sat_cnt(input logic [BYTE_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] sat_drop(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    logic       pclk_level_unused, pclk_rise;
    logic       vsync_level_unused, vsync_rise;
    logic       href_s, href_rise_unused;
    logic [7:0] data_s, data_rise_unused;

    dvp_sync #(.WIDTH(1)) u_sync_pclk (
        .clk(clk), .rst_n(rst_n), .async_in(bus.cam_pclk),
        .sync_out(pclk_level_unused), .rise(pclk_rise)
    );
    dvp_sync #(.WIDTH(1)) u_sync_vsync (
        .clk(clk), .rst_n(rst_n), .async_in(bus.cam_vsync),
        .sync_out(vsync_level_unused), .rise(vsync_rise)
    );
    dvp_sync #(.WIDTH(1)) u_sync_href (
        .clk(clk), .rst_n(rst_n), .async_in(bus.cam_href),
        .sync_out(href_s), .rise(href_rise_unused)
    );
    dvp_sync #(.WIDTH(8)) u_sync_data (
        .clk(clk), .rst_n(rst_n), .async_in(bus.cam_data),
        .sync_out(data_s), .rise(data_rise_unused)
    );

    cap_state_e            state, state_nxt;
    logic [DATA_WIDTH-1:0] acc, acc_nxt;
    logic [IDX_W-1:0]      idx;
    logic [BYTE_CNT_W-1:0] cnt, cnt_nxt;
    logic                  byte_stb, frame_close, emit, out_free;

    assign byte_stb = pclk_rise & href_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Dropping capture_en takes priority over a coincident frame boundary.
    always_comb begin
        state_nxt   = state;
        frame_close = 1'b0;
        case (state)
            ST_IDLE:    if (vsync_rise && capture_en) state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                if (!capture_en) state_nxt = ST_IDLE;
                else             frame_close = vsync_rise;
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // A byte landing on the closing cycle still belongs to the closing frame.
    always_comb begin
        acc_nxt = acc;
        cnt_nxt = cnt;
        if (byte_stb) begin
            acc_nxt = acc ^ (DATA_WIDTH'(data_s) << (BYTE_LANE_W * idx));
            cnt_nxt = sat_cnt(cnt);
        end
    end

    assign emit     = frame_close && (cnt_nxt != '0);
    assign out_free = !bus.delta_valid || bus.delta_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            idx <= '0;
            cnt <= '0;
        end else if (state != ST_CAPTURE || !capture_en || frame_close) begin
            acc <= '0;
            idx <= '0;
            cnt <= '0;
        end else if (byte_stb) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.frame_delta    <= '0;
            bus.frame_bytes    <= '0;
            bus.delta_valid    <= 1'b0;
            bus.frames_dropped <= '0;
        end else if (emit && out_free) begin
            bus.frame_delta <= acc_nxt;
            bus.frame_bytes <= cnt_nxt;
            bus.delta_valid <= 1'b1;
        end else begin
            if (emit) bus.frames_dropped <= sat_drop(bus.frames_dropped);
            if (bus.delta_valid && bus.delta_ready) bus.delta_valid <= 1'b0;
        end
    end
endmodule
